// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo encoder frame path: default frame geometry
// and the frame sequencer state encoding.
package turbo_pkg;

  localparam int unsigned K_LEN_DEF    = 16;
  localparam int unsigned TAIL_LEN_DEF = 3;
  localparam int unsigned AW_DEF       = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ENC   = 3'd2,
    S_TAIL  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } tfc_state_t;

endpackage

// File: rtl/turbo_frame_ctrl_if.sv
// Handshake/bus bundle between the frame sequencer and its neighbours.
// PUNCT_BYPASS_EN adds the rate_third select line.
interface turbo_frame_ctrl_if #(
  parameter int unsigned AW = 4
) ();

  logic          frame_req;
  logic          frame_ack;
  logic          abort;
  logic          din_valid;
  logic          din_ready;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic          enc_clr;
  logic          enc_en;
  logic          tail_en;
  logic          punct_start;
  logic          punct_over;
  logic          frame_done;
  logic          busy;
`ifdef PUNCT_BYPASS_EN
  logic          rate_third;
`endif

  // Sequencer side
  modport slave (
`ifdef PUNCT_BYPASS_EN
    input  rate_third,
`endif
    input  frame_req, abort, din_valid, punct_over,
    output frame_ack, din_ready, ram_we, ram_waddr, ram_re, ram_raddr,
           enc_clr, enc_en, tail_en, punct_start, frame_done, busy
  );

  // Frame source / datapath side
  modport master (
`ifdef PUNCT_BYPASS_EN
    output rate_third,
`endif
    output frame_req, abort, din_valid, punct_over,
    input  frame_ack, din_ready, ram_we, ram_waddr, ram_re, ram_raddr,
           enc_clr, enc_en, tail_en, punct_start, frame_done, busy
  );

endinterface

// File: rtl/turbo_seq_cnt.sv
// Loadable up-counter with clear, enable and terminal-count flag; saturates at TERM.
module turbo_seq_cnt #(
  parameter int unsigned W    = 4,
  parameter int unsigned TERM = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == W'(TERM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/turbo_frame_ctrl.sv
// Turbo encoder frame sequencer: load K_LEN bits, encode, terminate, wait for puncturing.
// Optional PUNCT_BYPASS_EN: rate_third (sampled at frame_ack) skips the puncture unit.
module turbo_frame_ctrl
  import turbo_pkg::*;
#(
  parameter int unsigned K_LEN    = K_LEN_DEF,
  parameter int unsigned TAIL_LEN = TAIL_LEN_DEF,
  parameter int unsigned AW       = AW_DEF
) (
  input logic              clk,
  input logic              rst_n,
  turbo_frame_ctrl_if.slave bus
);

  localparam logic [1:0] TAIL_LAST = 2'(TAIL_LEN - 1);

  tfc_state_t    state_q, state_d;
  logic          re_d_q;
  logic [1:0]    tail_cnt_q;
  logic          bypass_q;
  logic [AW-1:0] cnt;
  logic          cnt_tc, cnt_clr, cnt_en;

  logic ack, rdy, we, re, eclr, ten, pstart, done;

  turbo_seq_cnt #(
    .W    (AW),
    .TERM (K_LEN - 1)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (cnt_en),
    .cnt      (cnt),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    ack     = 1'b0;
    rdy     = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    eclr    = 1'b0;
    ten     = 1'b0;
    pstart  = 1'b0;
    done    = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.frame_req) begin
          state_d = S_LOAD;
          ack     = 1'b1;
        end
      end
      S_LOAD: begin
        rdy = 1'b1;
        if (bus.din_valid) begin
          we     = 1'b1;
          cnt_en = 1'b1;
          if (cnt_tc) begin
            state_d = S_ENC;
            cnt_clr = 1'b1;
            eclr    = 1'b1;
          end
        end
      end
      S_ENC: begin
        re     = 1'b1;
        cnt_en = 1'b1;
        pstart = re_d_q;
        if (cnt_tc) begin
          state_d = S_TAIL;
          cnt_clr = 1'b1;
        end
      end
      S_TAIL: begin
        // First TAIL cycle still carries the last data bit (re_d_q high)
        pstart = 1'b1;
        ten    = !re_d_q;
        if (ten && tail_cnt_q == TAIL_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        pstart = 1'b1;
        if (bypass_q || bus.punct_over) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bypass_q) pstart = 1'b0;
    if (bus.abort) begin
      state_d = S_IDLE;
      cnt_clr = 1'b1;
      cnt_en  = 1'b0;
      ack     = 1'b0;
      we      = 1'b0;
      eclr    = 1'b0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      re_d_q     <= 1'b0;
      tail_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      re_d_q  <= re && !bus.abort;
      if (state_q != S_TAIL || bus.abort) begin
        tail_cnt_q <= '0;
      end else if (ten) begin
        tail_cnt_q <= tail_cnt_q + 2'd1;
      end
    end
  end

`ifdef PUNCT_BYPASS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bypass_q <= 1'b0;
    end else if (ack) begin
      bypass_q <= bus.rate_third;
    end
  end
`else
  assign bypass_q = 1'b0;
`endif

  assign bus.frame_ack   = ack;
  assign bus.din_ready   = rdy;
  assign bus.ram_we      = we;
  assign bus.ram_waddr   = cnt;
  assign bus.ram_re      = re;
  assign bus.ram_raddr   = cnt;
  assign bus.enc_clr     = eclr;
  assign bus.enc_en      = re_d_q | ten;
  assign bus.tail_en     = ten;
  assign bus.punct_start = pstart;
  assign bus.frame_done  = done;
  assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_turbo_frame_ctrl.sv
// Directed bench for turbo_frame_ctrl: full frames, gapped load, late puncture,
// abort in ENC, reset in TAIL, and (with PUNCT_BYPASS_EN) the rate-1/3 bypass.
module tb_turbo_frame_ctrl;

  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  turbo_frame_ctrl_if #(.AW(AW)) bus ();

  turbo_frame_ctrl #(
    .K_LEN    (16),
    .TAIL_LEN (3),
    .AW       (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {bus.ram_raddr, bus.ram_waddr, bus.frame_ack, bus.din_ready, bus.ram_we,
            bus.ram_re, bus.enc_clr, bus.enc_en, bus.tail_en, bus.punct_start,
            bus.frame_done, bus.busy};
  endfunction

  // One frame from IDLE; cycle 0 is the frame_req/ack cycle.
  task automatic run_frame(input string nm, input bit toggle, input int over_delay,
                           input int exp_last_wr, input int exp_done_off,
                           input int abort_raddr, input bit rst_tail, input bit rate3);
    int acks = 0, wr = 0, rd = 0, clrs = 0, encs = 0, tails = 0, dones = 0;
    int last_wr = -1, clr_cyc = -1, e0 = -1, first_enc = -1, last_enc = -1;
    int pst = -1, done_cyc = -1, ev_cyc = -1, stop_at = -1;
    bit stop = 1'b0, aborted = 1'b0, rstd = 1'b0;
    for (int cyc = 0; cyc < 200 && !stop; cyc++) begin
      if (rstd && !rst_n) rst_n = 1'b1;
      bus.frame_req  = (cyc < 4);
      bus.din_valid  = toggle ? (cyc % 2 == 0) : 1'b1;
      bus.punct_over = (pst >= 0 && cyc >= pst + over_delay);
      bus.abort      = 1'b0;
`ifdef PUNCT_BYPASS_EN
      bus.rate_third = rate3;
`endif
      #1;
      if (abort_raddr >= 0 && !aborted && bus.ram_re && int'(bus.ram_raddr) == abort_raddr) begin
        bus.abort = 1'b1;
        aborted   = 1'b1;
        ev_cyc    = cyc;
        stop_at   = cyc + 6;
        #1;
      end
      if (aborted && cyc == ev_cyc + 1) check_eq({nm, "_abort_outs"}, outs(), 32'd0);
      if (bus.frame_ack) acks++;
      if (bus.ram_we) begin
        check_eq({nm, "_waddr"}, 32'(bus.ram_waddr), 32'(wr));
        wr++;
        last_wr = cyc;
      end
      if (bus.enc_clr) begin
        clrs++;
        clr_cyc = cyc;
      end
      if (bus.ram_re) begin
        if (e0 < 0) e0 = cyc;
        check_eq({nm, "_raddr"}, 32'(bus.ram_raddr), 32'(rd));
        rd++;
      end
      if (bus.enc_en) begin
        if (first_enc < 0) first_enc = cyc;
        last_enc = cyc;
        encs++;
      end
      if (bus.tail_en) tails++;
      if (bus.punct_start && pst < 0) pst = cyc;
      if (bus.frame_done) begin
        dones++;
        done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        check_eq({nm, "_busy_after"}, 32'(bus.busy), 32'd0);
        stop = 1'b1;
      end
      if (rst_tail && !rstd && tails == 1) begin
        rst_n = 1'b0;
        #1;
        check_eq({nm, "_rst_outs"}, outs(), 32'd0);
        rstd    = 1'b1;
        stop_at = cyc + 6;
      end
      if (stop_at >= 0 && cyc >= stop_at) stop = 1'b1;
      @(posedge clk);
      #1;
    end
    check_eq({nm, "_finished"}, 32'(stop), 32'd1);
    if (abort_raddr < 0 && !rst_tail) begin
      check_eq({nm, "_acks"}, acks, 1);
      check_eq({nm, "_writes"}, wr, 16);
      check_eq({nm, "_last_wr"}, last_wr, exp_last_wr);
      check_eq({nm, "_clrs"}, clrs, 1);
      check_eq({nm, "_clr_cyc"}, clr_cyc, exp_last_wr);
      check_eq({nm, "_first_re"}, e0, exp_last_wr + 1);
      check_eq({nm, "_reads"}, rd, 16);
      check_eq({nm, "_enc_en"}, encs, 19);
      check_eq({nm, "_first_enc"}, first_enc, exp_last_wr + 2);
      check_eq({nm, "_last_enc"}, last_enc, exp_last_wr + 20);
      check_eq({nm, "_tail_en"}, tails, 3);
      check_eq({nm, "_pstart"}, pst, rate3 ? -1 : exp_last_wr + 2);
      check_eq({nm, "_dones"}, dones, 1);
      check_eq({nm, "_done_cyc"}, done_cyc, exp_last_wr + 1 + exp_done_off);
    end else begin
      check_eq({nm, "_no_done"}, dones, 0);
      check_eq({nm, "_idle_after"}, 32'(bus.busy), 32'd0);
    end
    bus.frame_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.frame_req  = 1'b0;
    bus.abort      = 1'b0;
    bus.din_valid  = 1'b0;
    bus.punct_over = 1'b0;
`ifdef PUNCT_BYPASS_EN
    bus.rate_third = 1'b0;
`endif
    #12;
    check_eq("reset_outs", outs(), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_reset_outs", outs(), 32'd0);

    //        name      tog  dly last done abort rst r3
    run_frame("full",   0,   16,  16,  21,  -1,   0,  0);
    run_frame("gapped", 1,   16,  32,  21,  -1,   0,  0);
    run_frame("late",   0,   30,  16,  32,  -1,   0,  0);
    run_frame("abort",  0,   16,  16,  21,   7,   0,  0);
    run_frame("again",  0,   16,  16,  21,  -1,   0,  0);
    run_frame("rst",    0,   16,  16,  21,  -1,   1,  0);
    run_frame("resume", 0,   16,  16,  21,  -1,   0,  0);
`ifdef PUNCT_BYPASS_EN
    run_frame("bypass", 0, 1000,  16,  21,  -1,   0,  1);
    run_frame("punct",  0,   16,  16,  21,  -1,   0,  0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
